uart_tx_arbiter: RTL and testbench

//   Shares a single UART transmitter between NUM_REQ byte producers.
//   - Round-robin arbitration across requesters; one byte per grant.
//   - Drives the transmitter's data_in/wr_en pair and tracks its tx_busy.
//   - Each requester sees a one-cycle ack when its byte is handed over.
//   - Sits between the CPU/peripheral byte sources and the UART TX datapath.

---
 rtl/uart_tx_arbiter_if.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer / UART-transmitter bundle around the TX arbiter; the master modport is the arbiter side.
// UART_ARB_LOCK_EN adds the per-requester lock vector.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
);
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   ack;
   logic [7:0]           tx_data;
   logic                 tx_wr_en;
   logic                 tx_busy;
   logic [IDW-1:0]       grant_id;
   logic                 arb_busy;
`ifdef UART_ARB_LOCK_EN
   logic [NUM_REQ-1:0]   lock;

   modport master (
      input  req, req_data, tx_busy, lock,
      output ack, tx_data, tx_wr_en, grant_id, arb_busy
   );

   modport slave (
      output req, req_data, tx_busy, lock,
      input  ack, tx_data, tx_wr_en, grant_id, arb_busy
   );
`else
   modport master (
      input  req, req_data, tx_busy,
      output ack, tx_data, tx_wr_en, grant_id, arb_busy
   );

   modport slave (
      output req, req_data, tx_busy,
      input  ack, tx_data, tx_wr_en, grant_id, arb_busy
   );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among NUM_REQ byte producers (UART_ARB_LOCK_EN: sticky grant).
// Latency: req seen in IDLE -> tx_wr_en/ack next cycle; backpressure: no grant while tx_busy, one byte per frame.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   uart_tx_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     rr_nxt;
   logic [IDW-1:0]     grant_id;
   logic [IDW-1:0]     grant_nxt;
   logic [7:0]         tx_data;
   logic [7:0]         data_nxt;

   logic               found;
   logic [IDW-1:0]     winner;
   logic [IDW:0]       sum;
   logic [NUM_REQ-1:0] shifted;
   logic [7:0]         win_byte;

   // Rotating search from rr_ptr; the extra bit in sum keeps the modulo wrap exact.
   always_comb begin : pick
      found   = 1'b0;
      winner  = '0;
      sum     = '0;
      shifted = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         sum = {1'b0, rr_ptr} + (IDW+1)'(off);
         if (sum >= (IDW+1)'(NUM_REQ)) begin
            sum = sum - (IDW+1)'(NUM_REQ);
         end
         shifted = bus.req >> sum;
         if (!found && shifted[0]) begin
            found  = 1'b1;
            winner = sum[IDW-1:0];
         end
      end
`ifdef UART_ARB_LOCK_EN
      // A locked requester keeps the transmitter until it releases lock or runs dry.
      if (|(bus.lock & bus.req & (NUM_REQ'(1) << grant_id))) begin
         found  = 1'b1;
         winner = grant_id;
      end
`endif
   end

   always_comb begin : byte_mux
      win_byte = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDW'(i)) begin
            win_byte = bus.req_data[8*i +: 8];
         end
      end
   end

   always_comb begin : fsm_next
      state_nxt = state;
      rr_nxt    = rr_ptr;
      grant_nxt = grant_id;
      data_nxt  = tx_data;
      case (state)
         IDLE: begin
            if (found && !bus.tx_busy) begin
               grant_nxt = winner;
               data_nxt  = win_byte;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            rr_nxt    = (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         tx_data  <= 8'h00;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         grant_id <= grant_nxt;
         tx_data  <= data_nxt;
      end
   end

   // Strobes decode straight from the state register, so they clear as soon as reset asserts.
   assign bus.tx_wr_en = (state == LOAD);
   assign bus.ack      = (state == LOAD) ? (NUM_REQ'(1) << grant_id) : '0;
   assign bus.tx_data  = tx_data;
   assign bus.grant_id = grant_id;
   assign bus.arb_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle-by-cycle vector table plus hand sequences for reset and lock.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ = 4;
   localparam int IDW     = 2;
   localparam logic [31:0] D  = 32'h13121110;
   localparam logic [31:0] DA = 32'h131211A5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0]  req;
      logic [31:0] dat;
      logic        busy;
      logic [3:0]  e_ack;
      logic        e_wr;
      logic [1:0]  e_gid;
      logic [7:0]  e_data;
      logic        e_ab;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic add(input logic [3:0] r, input logic [31:0] d, input logic b,
                      input logic [3:0] a, input logic w, input logic [1:0] g,
                      input logic [7:0] x, input logic ab);
      vec_t v;
      v.req = r; v.dat = d; v.busy = b;
      v.e_ack = a; v.e_wr = w; v.e_gid = g; v.e_data = x; v.e_ab = ab;
      tbl.push_back(v);
   endtask

   // One normal frame: LOAD, WAIT_BUSY, WAIT_DONE, back to IDLE, with req held at r.
   task automatic add_frame(input logic [3:0] r, input logic [31:0] d, input logic [3:0] a,
                            input logic [1:0] g, input logic [7:0] x);
      add(r, d, 1'b0, a,       1'b1, g, x, 1'b1);
      add(r, d, 1'b0, 4'b0000, 1'b0, g, x, 1'b1);
      add(r, d, 1'b1, 4'b0000, 1'b0, g, x, 1'b1);
      add(r, d, 1'b0, 4'b0000, 1'b0, g, x, 1'b0);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_frame(input logic [3:0] r, input logic [3:0] a, input logic [1:0] g,
                           input logic [7:0] x, input string t);
      bus.req     = r;
      bus.tx_busy = 1'b0;
      step();
      chk({t, " ack"},  {28'd0, bus.ack},      {28'd0, a});
      chk({t, " wr"},   {31'd0, bus.tx_wr_en}, 32'd1);
      chk({t, " gid"},  {30'd0, bus.grant_id}, {30'd0, g});
      chk({t, " data"}, {24'd0, bus.tx_data},  {24'd0, x});
      step();
      chk({t, " wr off"}, {31'd0, bus.tx_wr_en}, 32'd0);
      bus.tx_busy = 1'b1;
      step();
      bus.tx_busy = 1'b0;
      step();
      chk({t, " idle"},    {31'd0, bus.arb_busy}, 32'd0);
      chk({t, " ack off"}, {28'd0, bus.ack},      32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Idle behaviour and a request blocked by a still-busy transmitter.
      add(4'b0000, D, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
      add(4'b0000, D, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
      add(4'b0001, D, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
      // All four held: rotation 0,1,2,3,0.
      add_frame(4'b1111, D, 4'b0001, 2'd0, 8'h10);
      add_frame(4'b1111, D, 4'b0010, 2'd1, 8'h11);
      add_frame(4'b1111, D, 4'b0100, 2'd2, 8'h12);
      add_frame(4'b1111, D, 4'b1000, 2'd3, 8'h13);
      add_frame(4'b1111, D, 4'b0001, 2'd0, 8'h10);
      // Single byte A5 from requester 0, with longer busy dwell.
      add(4'b0001, DA, 1'b0, 4'b0001, 1'b1, 2'd0, 8'hA5, 1'b1);
      add(4'b0001, DA, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b1);
      add(4'b0000, DA, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b1);
      add(4'b0000, DA, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b1);
      add(4'b0000, DA, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b1);
      add(4'b0000, DA, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b0);
      add(4'b0000, DA, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA5, 1'b0);
      // req[2] drops during LOAD: frame completes, no second ack.
      add(4'b0100, D, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b1);
      add(4'b0000, D, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h12, 1'b1);
      add(4'b0000, D, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h12, 1'b1);
      add(4'b0000, D, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h12, 1'b0);
      add(4'b0000, D, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h12, 1'b0);
      // Pointer wrap: grant 3, then 0 wins from rr_ptr=0, then 3 again from rr_ptr=1.
      add_frame(4'b1000, D, 4'b1000, 2'd3, 8'h13);
      add_frame(4'b1001, D, 4'b0001, 2'd0, 8'h10);
      add_frame(4'b1001, D, 4'b1000, 2'd3, 8'h13);
      add(4'b0000, D, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h13, 1'b0);

      bus.req      = 4'b0000;
      bus.req_data = D;
      bus.tx_busy  = 1'b0;
`ifdef UART_ARB_LOCK_EN
      bus.lock     = 4'b0000;
`endif
      rst_n = 1'b0;
      #12;
      chk("reset ack",  {28'd0, bus.ack},      32'd0);
      chk("reset wr",   {31'd0, bus.tx_wr_en}, 32'd0);
      chk("reset gid",  {30'd0, bus.grant_id}, 32'd0);
      chk("reset data", {24'd0, bus.tx_data},  32'd0);
      chk("reset busy", {31'd0, bus.arb_busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         bus.req      = tbl[i].req;
         bus.req_data = tbl[i].dat;
         bus.tx_busy  = tbl[i].busy;
         step();
         chk($sformatf("v%0d ack", i),  {28'd0, bus.ack},      {28'd0, tbl[i].e_ack});
         chk($sformatf("v%0d wr", i),   {31'd0, bus.tx_wr_en}, {31'd0, tbl[i].e_wr});
         chk($sformatf("v%0d gid", i),  {30'd0, bus.grant_id}, {30'd0, tbl[i].e_gid});
         chk($sformatf("v%0d data", i), {24'd0, bus.tx_data},  {24'd0, tbl[i].e_data});
         chk($sformatf("v%0d abusy", i), {31'd0, bus.arb_busy}, {31'd0, tbl[i].e_ab});
      end

      // Reset in WAIT_DONE with the transmitter still busy across release.
      bus.req      = 4'b0010;
      bus.req_data = D;
      bus.tx_busy  = 1'b0;
      step();
      chk("mid load wr",  {31'd0, bus.tx_wr_en}, 32'd1);
      chk("mid load gid", {30'd0, bus.grant_id}, 32'd1);
      step();
      bus.tx_busy = 1'b1;
      step();
      chk("mid wait_done", {31'd0, bus.arb_busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async ack",  {28'd0, bus.ack},      32'd0);
      chk("async wr",   {31'd0, bus.tx_wr_en}, 32'd0);
      chk("async busy", {31'd0, bus.arb_busy}, 32'd0);
      chk("async gid",  {30'd0, bus.grant_id}, 32'd0);
      chk("async data", {24'd0, bus.tx_data},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("post rst hold%0d wr", k),   {31'd0, bus.tx_wr_en}, 32'd0);
         chk($sformatf("post rst hold%0d abusy", k), {31'd0, bus.arb_busy}, 32'd0);
      end
      do_frame(4'b0010, 4'b0010, 2'd1, 8'h11, "post rst grant");

`ifdef UART_ARB_LOCK_EN
      bus.lock = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         do_frame(4'b0011, 4'b0010, 2'd1, 8'h11, $sformatf("lock%0d", k));
      end
      bus.lock = 4'b0000;
      do_frame(4'b0011, 4'b0001, 2'd0, 8'h10, "unlock");
`else
      do_frame(4'b0011, 4'b0001, 2'd0, 8'h10, "rr pair a");
      do_frame(4'b0011, 4'b0010, 2'd1, 8'h11, "rr pair b");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
